// File: rtl/clk_div_monitor_pkg.sv
// Shared definitions for the divided-clock monitor: FSM encodings and
// default parameter values.
package clk_div_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  localparam int unsigned DEF_CNT_W    = 8;
  localparam int unsigned DEF_TOL      = 0;
  localparam int unsigned DEF_LOCK_CNT = 4;
  localparam int unsigned DEF_TIMEOUT  = 255;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level, plus a delayed copy
// for single-cycle rising-edge detection in the clk domain.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic sync_dly_q;

  // NOTE: non-blocking assignments so each stage captures the previous stage's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q     <= 1'b0;
      sync_q     <= 1'b0;
      sync_dly_q <= 1'b0;
    end else begin
      meta_q     <= async_i;
      sync_q     <= meta_q;
      sync_dly_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~sync_dly_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period (and optionally high time) of clk_in in clk cycles and tracks
// lock to exp_div. Define CLK_DIV_MON_DUTY_EN to build the high-time/stuck-line check.
module clk_div_monitor
  import clk_div_monitor_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned TOL      = DEF_TOL,
  parameter int unsigned LOCK_CNT = DEF_LOCK_CNT,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  input  logic [CNT_W-1:0] exp_div,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             lost,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned      MC_W      = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = TIMEOUT[CNT_W-1:0];
  localparam logic [CNT_W:0]   TOL_C     = TOL[CNT_W:0];
  localparam logic [MC_W-1:0]  LOCK_C    = LOCK_CNT[MC_W-1:0];

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic sync;
  logic rise;

  sync_edge_det u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (clk_in),
    .sync_o  (sync),
    .rise_o  (rise)
  );

  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    per_cnt_d = sat_inc(per_cnt_q);
    if (rise) per_cnt_d = CNT_W'(1);
  end

  logic [CNT_W-1:0] hi_cnt;
  logic             duty_ok;
  logic             capture;

`ifdef CLK_DIV_MON_DUTY_EN
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] high_q;

  always_comb begin
    hi_cnt_d = hi_cnt_q;
    if (rise)      hi_cnt_d = CNT_W'(sync);
    else if (sync) hi_cnt_d = sat_inc(hi_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_cnt_q <= '0;
      high_q   <= '0;
    end else begin
      hi_cnt_q <= hi_cnt_d;
      if (capture) high_q <= hi_cnt_q;
    end
  end

  assign hi_cnt    = hi_cnt_q;
  // A line stuck high or low yields high time 0 or equal to the period.
  assign duty_ok   = (hi_cnt_q != '0) && (hi_cnt_q != per_cnt_q);
  assign high_time = high_q;
`else
  logic unused_sync;
  assign unused_sync = sync;
  assign hi_cnt      = '0;
  assign duty_ok     = 1'b1;
  assign high_time   = '0;
`endif

  // One extra bit keeps the difference from wrapping.
  logic [CNT_W:0] per_x, exp_x, abs_diff;
  logic           match;

  assign per_x    = {1'b0, per_cnt_q};
  assign exp_x    = {1'b0, exp_div};
  assign abs_diff = (per_x >= exp_x) ? (per_x - exp_x) : (exp_x - per_x);
  assign match    = (exp_div != '0) && (abs_diff <= TOL_C) && duty_ok;

  state_e           state_q, state_d;
  logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             mv_q, lost_q, lost_d, locked_q;

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    err_d       = err_q;
    period_d    = period_q;
    capture     = 1'b0;
    lost_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d     = ST_MEASURE;
          match_cnt_d = '0;
        end
      end
      ST_MEASURE, ST_LOCKED: begin
        if (rise) begin
          capture  = 1'b1;
          period_d = per_cnt_q;
          if (match) begin
            if (state_q == ST_MEASURE) begin
              match_cnt_d = match_cnt_q + MC_W'(1);
              if (match_cnt_d == LOCK_C) state_d = ST_LOCKED;
            end
          end else begin
            match_cnt_d = '0;
            err_d       = sat_inc(err_q);
            if (state_q == ST_LOCKED) begin
              state_d = ST_MEASURE;
              lost_d  = 1'b1;
            end
          end
        end else if (per_cnt_q == TIMEOUT_C) begin
          state_d     = ST_IDLE;
          match_cnt_d = '0;
          err_d       = sat_inc(err_q);
          lost_d      = (state_q == ST_LOCKED);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      match_cnt_q <= '0;
      err_q       <= '0;
      period_q    <= '0;
      per_cnt_q   <= '0;
      mv_q        <= 1'b0;
      lost_q      <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      err_q       <= err_d;
      period_q    <= period_d;
      per_cnt_q   <= per_cnt_d;
      mv_q        <= capture;
      lost_q      <= lost_d;
      locked_q    <= (state_d == ST_LOCKED);
    end
  end

  assign period     = period_q;
  assign meas_valid = mv_q;
  assign locked     = locked_q;
  assign lost       = lost_q;
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: three instances (default tolerance,
// TOL=1, 4-bit counters) driven by cycle-exact divided-clock generators.
module tb_clk_div_monitor;

  localparam int TIMEOUT_A = 40;
`ifdef CLK_DIV_MON_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] cin;

  logic [7:0] exp_a, per_a, hi_a, err_a;
  logic       mv_a, lk_a, ls_a;
  logic [7:0] exp_b, per_b, hi_b, err_b;
  logic       mv_b, lk_b, ls_b;
  logic [3:0] exp_c, per_c, hi_c, err_c;
  logic       mv_c, lk_c, ls_c;

  int checks   = 0;
  int failures = 0;

  int gen_ratio[3];
  int gen_next[3];
  int gen_ph[3];
  bit gen_en[3];

  always #5 clk = ~clk;

  clk_div_monitor #(.CNT_W(8), .TOL(0), .LOCK_CNT(4), .TIMEOUT(TIMEOUT_A)) dut_a (
    .clk(clk), .rst(rst), .clk_in(cin[0]), .exp_div(exp_a), .period(per_a),
    .high_time(hi_a), .meas_valid(mv_a), .locked(lk_a), .lost(ls_a), .err_cnt(err_a)
  );

  clk_div_monitor #(.CNT_W(8), .TOL(1), .LOCK_CNT(4), .TIMEOUT(255)) dut_b (
    .clk(clk), .rst(rst), .clk_in(cin[1]), .exp_div(exp_b), .period(per_b),
    .high_time(hi_b), .meas_valid(mv_b), .locked(lk_b), .lost(ls_b), .err_cnt(err_b)
  );

  clk_div_monitor #(.CNT_W(4), .TOL(0), .LOCK_CNT(4), .TIMEOUT(15)) dut_c (
    .clk(clk), .rst(rst), .clk_in(cin[2]), .exp_div(exp_c), .period(per_c),
    .high_time(hi_c), .meas_valid(mv_c), .locked(lk_c), .lost(ls_c), .err_cnt(err_c)
  );

  typedef struct {
    int ratio;
    int exp_div;
    int n_meas;
    int e_period;
    int e_high;
    bit e_locked;
    int e_err;
    int e_lost;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic mv(input int ch);
    case (ch)
      0:       return mv_a;
      1:       return mv_b;
      default: return mv_c;
    endcase
  endfunction

  function automatic logic ls(input int ch);
    case (ch)
      0:       return ls_a;
      1:       return ls_b;
      default: return ls_c;
    endcase
  endfunction

  // A new ratio takes effect at the next clk_in rising edge.
  task automatic tick();
    for (int i = 0; i < 3; i++) begin
      if (gen_en[i]) begin
        gen_ph[i]++;
        if (gen_ph[i] >= gen_ratio[i]) begin
          gen_ph[i]    = 0;
          gen_ratio[i] = gen_next[i];
        end
        cin[i] = (gen_ph[i] < gen_ratio[i] / 2);
      end else begin
        cin[i] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_gen(input int ch, input int ratio);
    gen_en[ch]    = 1'b1;
    gen_ratio[ch] = ratio;
    gen_next[ch]  = ratio;
    gen_ph[ch]    = ratio - 1;
  endtask

  task automatic run_meas(input int ch, input int n, output int lost_n);
    int got;
    int cyc;
    got    = 0;
    cyc    = 0;
    lost_n = 0;
    while (got < n && cyc < 2000) begin
      tick();
      cyc++;
      if (mv(ch)) got++;
      if (ls(ch)) lost_n++;
    end
    check($sformatf("meas_count_ch%0d", ch), got, n);
  endtask

  initial begin
    vec_t vecs[8];
    int   lost_n;
    int   cyc;
    int   last_mv;
    int   lost_at;
    int   n;

    vecs[0] = '{3, 3, 3, 3, 1, 1'b0, 0, 0};
    vecs[1] = '{3, 3, 1, 3, 1, 1'b1, 0, 0};
    vecs[2] = '{3, 3, 3, 3, 1, 1'b1, 0, 0};
    vecs[3] = '{4, 3, 2, 4, 2, 1'b0, 1, 1};
    vecs[4] = '{4, 3, 6, 4, 2, 1'b0, 7, 0};
    vecs[5] = '{4, 4, 4, 4, 2, 1'b1, 7, 0};
    vecs[6] = '{4, 0, 1, 4, 2, 1'b0, 8, 1};
    vecs[7] = '{2, 2, 5, 2, 1, 1'b1, 9, 0};

    for (int i = 0; i < 3; i++) gen_en[i] = 1'b0;
    cin   = '0;
    exp_a = 8'd3;
    exp_b = 8'd3;
    exp_c = 4'd2;
    rst   = 1'b1;
    repeat (3) tick();
    check("rst_period",  32'(per_a), 0);
    check("rst_high",    32'(hi_a),  0);
    check("rst_valid",   32'(mv_a),  0);
    check("rst_locked",  32'(lk_a),  0);
    check("rst_lost",    32'(ls_a),  0);
    check("rst_err",     32'(err_a), 0);
    rst = 1'b0;

    // TOL=1: ratio 4 against exp_div 3 still locks
    start_gen(1, 4);
    run_meas(1, 3, lost_n);
    check("tol_locked_early", 32'(lk_b), 0);
    run_meas(1, 1, lost_n);
    check("tol_locked",  32'(lk_b),  1);
    check("tol_period",  32'(per_b), 4);
    check("tol_err",     32'(err_b), 0);
    gen_en[1] = 1'b0;

    // 4-bit error counter saturates at 15 (20 edges -> 19 mismatches)
    start_gen(2, 3);
    run_meas(2, 15, lost_n);
    check("sat_err_15",  32'(err_c), 15);
    run_meas(2, 4, lost_n);
    check("sat_err_hold", 32'(err_c), 15);
    check("sat_period",  32'(per_c), 3);
    check("sat_locked",  32'(lk_c),  0);
    gen_en[2] = 1'b0;

    start_gen(0, vecs[0].ratio);
    for (int v = 0; v < 8; v++) begin
      gen_next[0] = vecs[v].ratio;
      exp_a       = 8'(vecs[v].exp_div);
      run_meas(0, vecs[v].n_meas, lost_n);
      check($sformatf("v%0d_period", v), 32'(per_a), vecs[v].e_period);
      check($sformatf("v%0d_high", v),   32'(hi_a),   DUTY ? vecs[v].e_high : 0);
      check($sformatf("v%0d_locked", v), 32'(lk_a),   32'(vecs[v].e_locked));
      check($sformatf("v%0d_err", v),    32'(err_a),  vecs[v].e_err);
      check($sformatf("v%0d_lost", v),   lost_n,      vecs[v].e_lost);
    end

    // Hold clk_in low while locked: loss exactly TIMEOUT cycles after last measurement
    gen_en[0] = 1'b0;
    cyc     = 0;
    last_mv = 0;
    lost_at = -1;
    while (lost_at < 0 && cyc < 1000) begin
      tick();
      cyc++;
      if (mv_a) last_mv = cyc;
      if (ls_a) lost_at = cyc;
    end
    check("timeout_gap",    lost_at - last_mv, TIMEOUT_A);
    check("timeout_locked", 32'(lk_a),  0);
    check("timeout_err",    32'(err_a), 10);
    tick();
    check("timeout_lost_width", 32'(ls_a), 0);

    // Restart: one edge to leave IDLE, then four matching measurements
    start_gen(0, 2);
    n   = 0;
    cyc = 0;
    while (!lk_a && cyc < 200) begin
      tick();
      cyc++;
      if (mv_a) n++;
    end
    check("relock_meas",    n, 4);
    check("relock_locked",  32'(lk_a),  1);
    check("relock_err",     32'(err_a), 10);

    // Single-cycle reset while locked
    rst = 1'b1;
    tick();
    check("mid_rst_period", 32'(per_a), 0);
    check("mid_rst_high",   32'(hi_a),  0);
    check("mid_rst_valid",  32'(mv_a),  0);
    check("mid_rst_locked", 32'(lk_a),  0);
    check("mid_rst_lost",   32'(ls_a),  0);
    check("mid_rst_err",    32'(err_a), 0);
    rst = 1'b0;
    tick();
    check("post_rst_lost",  32'(ls_a),  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
